// File: rtl/alu_uart_ctrl_pkg.sv
// Shared definitions for the UART-to-ALU sequencer: state encoding and frame
// geometry.
package alu_uart_pkg;

   localparam int FRAME_LEN = 3;

   localparam logic [2:0] ST_WAIT_A  = 3'd0;
   localparam logic [2:0] ST_WAIT_B  = 3'd1;
   localparam logic [2:0] ST_WAIT_OP = 3'd2;
   localparam logic [2:0] ST_EXEC    = 3'd3;
   localparam logic [2:0] ST_SEND    = 3'd4;
   localparam logic [2:0] ST_WAIT_TX = 3'd5;

   typedef enum logic [2:0] {
      WAIT_A  = ST_WAIT_A,
      WAIT_B  = ST_WAIT_B,
      WAIT_OP = ST_WAIT_OP,
      EXEC    = ST_EXEC,
      SEND    = ST_SEND,
      WAIT_TX = ST_WAIT_TX
   } state_t;

   // Between the first and last byte of a frame: the inter-byte timer runs.
   function automatic logic in_frame(input state_t s);
      return (s == WAIT_B) || (s == WAIT_OP);
   endfunction

   // From the opcode capture until TX reports completion.
   function automatic logic is_busy(input state_t s);
      return (s == EXEC) || (s == SEND) || (s == WAIT_TX);
   endfunction

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// Bundle of the RX/TX/ALU signals seen by the sequencer; slave is the
// sequencer side, master is the board/environment side.
interface alu_uart_ctrl_if #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
);

   logic [NB_DATA-1:0] i_rx_data;
   logic               i_rx_done;
   logic               i_tx_done;
   logic [NB_DATA-1:0] i_alu_result;

   logic [NB_DATA-1:0] o_alu_data_A;
   logic [NB_DATA-1:0] o_alu_data_B;
   logic [NB_OP-1:0]   o_alu_op;
   logic [NB_DATA-1:0] o_tx_data;
   logic               o_tx_start;
   logic               o_busy;
   logic               o_err;
   logic               o_overrun;

   modport slave (
      input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
      output o_alu_data_A, o_alu_data_B, o_alu_op, o_tx_data,
             o_tx_start, o_busy, o_err, o_overrun
   );

   modport master (
      output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
      input  o_alu_data_A, o_alu_data_B, o_alu_op, o_tx_data,
             o_tx_start, o_busy, o_err, o_overrun
   );

endinterface

// File: rtl/alu_uart_ctrl_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count sits at TIMEOUT_CYC-1.
module timeout_timer #(
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int               CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count_q;

   // NOTE: sequential state is assigned with <= only, so every register
   // samples the pre-edge value of its sources regardless of block order.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         count_q <= '0;
      end else if (i_clear) begin
         count_q <= '0;
      end else if (i_enable && (count_q != LAST)) begin
         count_q <= count_q + 1'b1;
      end
   end

   // A byte arriving in the expiry cycle clears the count and wins.
   assign o_expired = i_enable && !i_clear && (count_q == LAST);

endmodule

// File: rtl/alu_uart_ctrl.sv
// Sequencer between UART RX/TX and a combinational ALU: collects A, B, opcode
// bytes, samples the ALU result and hands it to TX with a start/done handshake.
module alu_uart_ctrl
   import alu_uart_pkg::*;
#(
   parameter int NB_DATA     = 8,
   parameter int NB_OP       = 6,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic            i_clk,
   input  logic            i_reset,
   alu_uart_ctrl_if.slave  bus
);

   state_t state_q;
   state_t state_d;

   logic load_a;
   logic load_b;
   logic load_op;
   logic load_tx;
   logic expired;
   logic timeout_hit;
   logic busy;

   logic [NB_DATA-1:0] data_a_q;
   logic [NB_DATA-1:0] data_b_q;
   logic [NB_OP-1:0]   op_q;
   logic [NB_DATA-1:0] tx_data_q;
   logic               err_q;
   logic               overrun_q;

   timeout_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (bus.i_rx_done),
      .i_enable  (in_frame(state_q)),
      .o_expired (expired)
   );

   assign busy        = is_busy(state_q);
   assign timeout_hit = expired;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q <= WAIT_A;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      load_a  = 1'b0;
      load_b  = 1'b0;
      load_op = 1'b0;
      load_tx = 1'b0;
      unique case (state_q)
         WAIT_A: begin
            if (bus.i_rx_done) begin
               load_a  = 1'b1;
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            if (bus.i_rx_done) begin
               load_b  = 1'b1;
               state_d = WAIT_OP;
            end else if (timeout_hit) begin
               state_d = WAIT_A;
            end
         end
         WAIT_OP: begin
            if (bus.i_rx_done) begin
               load_op = 1'b1;
               state_d = EXEC;
            end else if (timeout_hit) begin
               state_d = WAIT_A;
            end
         end
         EXEC: begin
            load_tx = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            state_d = WAIT_TX;
         end
         WAIT_TX: begin
            if (bus.i_tx_done) begin
               state_d = WAIT_A;
            end
         end
         default: begin
            state_d = WAIT_A;
         end
      endcase
   end

   // NOTE: these are a handful of control-visible registers, not a memory
   // array, so they carry a reset and start from a known 0.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         data_a_q  <= '0;
         data_b_q  <= '0;
         op_q      <= '0;
         tx_data_q <= '0;
         err_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (load_a)  data_a_q  <= bus.i_rx_data;
         if (load_b)  data_b_q  <= bus.i_rx_data;
         if (load_op) op_q      <= bus.i_rx_data[NB_OP-1:0];
         if (load_tx) tx_data_q <= bus.i_alu_result;
         err_q     <= timeout_hit;
         overrun_q <= bus.i_rx_done && busy;
      end
   end

   // Upper opcode-byte bits are deliberately discarded.
   generate
      if (NB_OP < NB_DATA) begin : g_op_hi
         logic unused_op_hi;
         assign unused_op_hi = ^bus.i_rx_data[NB_DATA-1:NB_OP];
      end
   endgenerate

   assign bus.o_alu_data_A = data_a_q;
   assign bus.o_alu_data_B = data_b_q;
   assign bus.o_alu_op     = op_q;
   assign bus.o_tx_data    = tx_data_q;
   assign bus.o_tx_start   = (state_q == SEND);
   assign bus.o_busy       = busy;
   assign bus.o_err        = err_q;
   assign bus.o_overrun    = overrun_q;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed plus randomized bench for alu_uart_ctrl with a behavioural ALU and
// frame-level reference model.
module tb_alu_uart_ctrl;
   import alu_uart_pkg::*;

   localparam int NB_DATA     = 8;
   localparam int NB_OP       = 6;
   localparam int TIMEOUT_CYC = 16;
   localparam int N_RAND      = 40;
   localparam logic [5:0] OPS [8] = '{6'h20, 6'h22, 6'h24, 6'h25,
                                       6'h26, 6'h27, 6'h02, 6'h03};

   logic i_clk;
   logic i_reset;
   int   n_checks;
   int   n_errors;
   int   tx_start_seen;
   int   err_seen;
   int   overrun_seen;

   alu_uart_ctrl_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

   alu_uart_ctrl #(
      .NB_DATA     (NB_DATA),
      .NB_OP       (NB_OP),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         6'h02:   return a >> b;
         6'h03:   return $signed(a) >>> b;
         default: return 8'h00;
      endcase
   endfunction

   assign bus.i_alu_result = alu_model(bus.o_alu_data_A, bus.o_alu_data_B, bus.o_alu_op);

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   always @(negedge i_clk) begin
      if (bus.o_tx_start) tx_start_seen++;
      if (bus.o_err)      err_seen++;
      if (bus.o_overrun)  overrun_seen++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [7:0] b);
      bus.i_rx_data = b;
      bus.i_rx_done = 1'b1;
      tick();
      bus.i_rx_done = 1'b0;
   endtask

   task automatic pulse_tx_done();
      bus.i_tx_done = 1'b1;
      tick();
      bus.i_tx_done = 1'b0;
   endtask

   logic [7:0] a, b, opb, exp_res;
   int         s0, e0, o0, got, g1, g2;

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      tx_start_seen = 0;
      err_seen      = 0;
      overrun_seen  = 0;
      bus.i_rx_data = '0;
      bus.i_rx_done = 1'b0;
      bus.i_tx_done = 1'b0;
      i_reset       = 1'b0;
      idle(2);

      check("rst_a",       bus.o_alu_data_A, 0);
      check("rst_b",       bus.o_alu_data_B, 0);
      check("rst_op",      bus.o_alu_op, 0);
      check("rst_tx_data", bus.o_tx_data, 0);
      check("rst_outs",    {bus.o_tx_start, bus.o_busy, bus.o_err, bus.o_overrun}, 0);
      i_reset = 1'b1;
      tick();

      // ADD frame with exact start latency
      send(8'h05);
      send(8'h03);
      check("add_a", bus.o_alu_data_A, 8'h05);
      check("add_b", bus.o_alu_data_B, 8'h03);
      send(8'h20);
      check("add_op",         bus.o_alu_op, 6'h20);
      check("add_exec_busy",  bus.o_busy, 1);
      check("add_exec_start", bus.o_tx_start, 0);
      tick();
      check("add_send_start", bus.o_tx_start, 1);
      check("add_tx_data",    bus.o_tx_data, 8'h08);
      tick();
      check("add_wait_start", bus.o_tx_start, 0);
      idle(3);
      check("add_wait_busy",  bus.o_busy, 1);
      pulse_tx_done();
      check("add_done_busy",  bus.o_busy, 0);

      // SUB with TX completion held off
      send(8'h03);
      send(8'h05);
      s0 = tx_start_seen;
      send(8'h22);
      idle(51);
      check("sub_tx_data",   bus.o_tx_data, 8'hFE);
      check("sub_busy_hold", bus.o_busy, 1);
      check("sub_one_start", tx_start_seen - s0, 1);
      pulse_tx_done();
      check("sub_done_busy", bus.o_busy, 0);

      // Timeout after operand A, then a clean AND frame
      e0  = err_seen;
      got = 0;
      send(8'h11);
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus.o_err) begin
            got = k;
            break;
         end
      end
      check("tmo_err_latency", got, TIMEOUT_CYC);
      tick();
      check("tmo_err_pulse", err_seen - e0, 1);
      check("tmo_a_kept",    bus.o_alu_data_A, 8'h11);
      send(8'h0F);
      send(8'hF0);
      send(8'h24);
      check("tmo_restart_a", bus.o_alu_data_A, 8'h0F);
      tick();
      check("and_start",   bus.o_tx_start, 1);
      check("and_tx_data", bus.o_tx_data, 8'h00);
      tick();
      pulse_tx_done();

      // Overrun while waiting for TX
      send(8'h0A);
      send(8'h04);
      send(8'h26);
      idle(2);
      o0 = overrun_seen;
      send(8'h77);
      check("ovr_high", bus.o_overrun, 1);
      tick();
      check("ovr_low",     bus.o_overrun, 0);
      check("ovr_pulse",   overrun_seen - o0, 1);
      check("ovr_a",       bus.o_alu_data_A, 8'h0A);
      check("ovr_b",       bus.o_alu_data_B, 8'h04);
      check("ovr_op",      bus.o_alu_op, 6'h26);
      check("ovr_tx_data", bus.o_tx_data, 8'h0E);
      check("ovr_busy",    bus.o_busy, 1);
      pulse_tx_done();
      send(8'h09);
      send(8'h02);
      send(8'h20);
      tick();
      check("ovr_next_tx", bus.o_tx_data, 8'h0B);
      tick();
      pulse_tx_done();

      // Reset mid-frame and mid-transmission
      send(8'h12);
      check("mid_a", bus.o_alu_data_A, 8'h12);
      i_reset = 1'b0;
      tick();
      i_reset = 1'b1;
      check("mrst_a",    bus.o_alu_data_A, 0);
      check("mrst_op",   bus.o_alu_op, 0);
      check("mrst_tx",   bus.o_tx_data, 0);
      check("mrst_outs", {bus.o_tx_start, bus.o_busy, bus.o_err, bus.o_overrun}, 0);
      send(8'h01);
      send(8'h01);
      send(8'h20);
      check("mrst_frame_a", bus.o_alu_data_A, 8'h01);
      tick();
      check("mrst_frame_tx", bus.o_tx_data, 8'h02);
      tick();
      i_reset = 1'b0;
      tick();
      i_reset = 1'b1;
      check("txrst_busy", bus.o_busy, 0);
      check("txrst_tx",   bus.o_tx_data, 0);

      // Upper opcode bits ignored; byte on the expiry cycle is accepted
      send(8'h40);
      send(8'h02);
      send(8'hE0);
      check("op_mask", bus.o_alu_op, 6'h20);
      tick();
      check("op_mask_tx", bus.o_tx_data, 8'h42);
      tick();
      pulse_tx_done();
      e0 = err_seen;
      send(8'h33);
      idle(TIMEOUT_CYC - 1);
      send(8'h46);
      check("edge_b_accepted", bus.o_alu_data_B, 8'h46);
      idle(2);
      check("edge_no_err", err_seen - e0, 0);
      send(8'h24);
      tick();
      check("edge_tx", bus.o_tx_data, 8'h02);
      tick();
      pulse_tx_done();

      // Randomized frames against the reference model
      for (int f = 0; f < N_RAND; f++) begin
         if ($urandom_range(4, 0) == 0) begin
            e0 = err_seen;
            send(8'($urandom));
            idle(TIMEOUT_CYC + 1);
            check("rand_abandon_err", err_seen - e0, 1);
         end
         a   = 8'($urandom);
         b   = 8'($urandom);
         opb = {2'($urandom), OPS[$urandom_range(7, 0)]};
         g1  = $urandom_range(TIMEOUT_CYC - 1, 0);
         g2  = $urandom_range(TIMEOUT_CYC - 1, 0);
         exp_res = alu_model(a, b, opb[5:0]);
         e0 = err_seen;
         for (int i = 0; i < FRAME_LEN; i++) begin
            send((i == 0) ? a : (i == 1) ? b : opb);
            if (i == 0) idle(g1);
            if (i == 1) idle(g2);
         end
         check("rand_a",  bus.o_alu_data_A, a);
         check("rand_b",  bus.o_alu_data_B, b);
         check("rand_op", bus.o_alu_op, opb[5:0]);
         tick();
         check("rand_start", bus.o_tx_start, 1);
         check("rand_tx",    bus.o_tx_data, exp_res);
         tick();
         if ($urandom_range(2, 0) == 0) begin
            o0 = overrun_seen;
            send(8'($urandom));
            tick();
            check("rand_ovr",    overrun_seen - o0, 1);
            check("rand_ovr_tx", bus.o_tx_data, exp_res);
         end
         idle($urandom_range(5, 0));
         check("rand_no_err", err_seen - e0, 0);
         pulse_tx_done();
         check("rand_idle", bus.o_busy, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
